vga_number_display: RTL and testbench

VGA_NUMBER_DISPLAY -- requirements
Module: vga_number_display

---
 rtl/vga_number_display.sv | 152 +++++++++++++++
 tb/tb_vga_number_display.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_number_display.sv
// Renders a DIGITS-wide hex number as seven-segment glyphs around a centre point.
// Values are staged in a pending register and applied on frame_start; 2-cycle pixel pipeline.
module vga_number_display #(
  parameter int DIGITS       = 4,
  parameter int PITCH        = 40,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [10:0]           center_x,
  input  logic [10:0]           center_y,
  input  logic [4*DIGITS-1:0]   number,
  input  logic                  load,
  input  logic                  frame_start,
  input  logic                  blink_en,
  input  logic                  lz_blank,
  output logic                  pending,
  output logic                  show
);

  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic                pending_q, pending_d;
  logic [7:0]          frame_cnt_q, frame_cnt_d;
  logic                phase_q, phase_d;
  logic                show_q, show_d;
  logic [DIGITS-1:0]   hit;

  // Glyph bit order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] glyph(input logic [3:0] val);
    logic [6:0] segs;
    case (val)
      4'h0: segs = 7'h3F;
      4'h1: segs = 7'h06;
      4'h2: segs = 7'h5B;
      4'h3: segs = 7'h4F;
      4'h4: segs = 7'h66;
      4'h5: segs = 7'h6D;
      4'h6: segs = 7'h7D;
      4'h7: segs = 7'h07;
      4'h8: segs = 7'h7F;
      4'h9: segs = 7'h6F;
      4'hA: segs = 7'h77;
      4'hB: segs = 7'h7C;
      4'hC: segs = 7'h39;
      4'hD: segs = 7'h5E;
      4'hE: segs = 7'h79;
      default: segs = 7'h71;
    endcase
    return segs;
  endfunction

  function automatic logic seg_hit(input logic [6:0] s, input logic [4:0] u, input logic [5:0] v);
    logic top, bot;
    top = (v <= 6'd19);
    bot = (v >= 6'd20);
    return (s[0] && v <= 6'd3)
        || (s[6] && v >= 6'd18 && v <= 6'd21)
        || (s[3] && v >= 6'd36)
        || (s[5] && u <= 5'd3  && top)
        || (s[1] && u >= 5'd20 && top)
        || (s[4] && u <= 5'd3  && bot)
        || (s[2] && u >= 5'd20 && bot);
  endfunction

  always_comb begin
    pend_val_d  = pend_val_q;
    disp_d      = disp_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (frame_start) begin
      if (pending_q) begin
        disp_d    = pend_val_q;
        pending_d = 1'b0;
      end
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
    // A simultaneous load lands after the transfer, so it stays pending.
    if (load) begin
      pend_val_d = number;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val_q  <= '0;
      disp_q      <= '0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      phase_q     <= 1'b1;
      show_q      <= 1'b0;
    end else begin
      pend_val_q  <= pend_val_d;
      disp_q      <= disp_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      show_q      <= show_d;
    end
  end

  logic signed [12:0] v_full;
  assign v_full = $signed({2'b00, y}) - ($signed({2'b00, center_y}) - 13'sd20);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    localparam int OFFS = ((DIGITS - 1 - 2 * gi) * PITCH) / 2;

    logic signed [12:0] cx, u_full;
    logic               inbox_d, inbox_q, blank;
    logic [4:0]         u_q;
    logic [5:0]         v_q;

    assign cx      = $signed({2'b00, center_x}) + 13'(OFFS);
    assign u_full  = $signed({2'b00, x}) - cx + 13'sd12;
    // Signed range checks keep out-of-range coordinates from aliasing into the box.
    assign inbox_d = !u_full[12] && (u_full < 13'sd24) && !v_full[12] && (v_full < 13'sd40);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inbox_q <= 1'b0;
        u_q     <= 5'd0;
        v_q     <= 6'd0;
      end else begin
        inbox_q <= inbox_d;
        u_q     <= u_full[4:0];
        v_q     <= v_full[5:0];
      end
    end

    if (gi == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_upper
      assign blank = lz_blank && (disp_q[4*DIGITS-1:4*gi] == '0);
    end

    assign hit[gi] = inbox_q && !blank && seg_hit(glyph(disp_q[4*gi +: 4]), u_q, v_q);
  end

  assign show_d  = (|hit) && !(blink_en && !phase_q);
  assign show    = show_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_vga_number_display.sv
// Directed bench for vga_number_display: probes glyph pixels, expected results are queued
// at issue time and checked by a monitor when the tagged sample leaves the 2-cycle pipeline.
module tb_vga_number_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x, y, center_x, center_y;
  logic [15:0] number;
  logic        load, frame_start, blink_en, lz_blank;
  logic        pending, show;

  always #5 clk = ~clk;

  vga_number_display #(.DIGITS(4), .PITCH(40), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .center_x(center_x), .center_y(center_y),
    .number(number), .load(load), .frame_start(frame_start), .blink_en(blink_en),
    .lz_blank(lz_blank), .pending(pending), .show(show)
  );

  typedef struct {
    logic  exp_show;
    logic  chk_pend;
    logic  exp_pend;
    string name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  logic probe_v = 1'b0, v1 = 1'b0, v2 = 1'b0;

  always @(posedge clk) begin
    v1 <= probe_v;
    v2 <= v1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (v2) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_sample: show=%b with empty scoreboard", show);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if (show !== e.exp_show) begin
          failures++;
          $display("FAIL %s: show=%b expected %b", e.name, show, e.exp_show);
        end else
          $display("ok   %s: show=%b", e.name, show);
        if (e.chk_pend) begin
          checks++;
          if (pending !== e.exp_pend) begin
            failures++;
            $display("FAIL %s_pending: pending=%b expected %b", e.name, pending, e.exp_pend);
          end
        end
      end
    end
  end

  task automatic chk(input logic act, input logic exp, input string nm);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end else
      $display("ok   %s: %b", nm, act);
  endtask

  task automatic probe(input int px, input int py, input logic es, input logic cp,
                       input logic ep, input string nm);
    exp_t e;
    @(negedge clk);
    x = 11'(px);
    y = 11'(py);
    e.exp_show = es;
    e.chk_pend = cp;
    e.exp_pend = ep;
    e.name     = nm;
    sb_q.push_back(e);
    probe_v = 1'b1;
    @(negedge clk);
    probe_v = 1'b0;
    for (int i = 0; i < 8 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: queue=%0d expected 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  // Digit k box starts at x = 248 + 40*(3-k) for centre (320,240); box top is y = 220.
  task automatic pseg(input int k, input byte s, input logic es, input logic cp,
                      input logic ep, input string nm);
    int u, v;
    case (s)
      "a": begin u = 12; v = 1;  end
      "b": begin u = 22; v = 10; end
      "c": begin u = 22; v = 30; end
      "d": begin u = 12; v = 38; end
      "e": begin u = 1;  v = 30; end
      "f": begin u = 1;  v = 10; end
      default: begin u = 12; v = 20; end
    endcase
    probe(248 + 40 * (3 - k) + u, 220 + v, es, cp, ep, nm);
  endtask

  task automatic do_load(input logic [15:0] val);
    @(negedge clk);
    number = val;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_fs(input logic with_load, input logic [15:0] val);
    @(negedge clk);
    frame_start = 1'b1;
    load = with_load;
    number = val;
    @(negedge clk);
    frame_start = 1'b0;
    load = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; x = '0; y = '0; center_x = 11'd320; center_y = 11'd240;
    number = '0; load = 1'b0; frame_start = 1'b0; blink_en = 1'b0; lz_blank = 1'b0;
    #1;
    chk(show, 1'b0, "reset_show");
    chk(pending, 1'b0, "reset_pending");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    pseg(3, "a", 1'b1, 1'b1, 1'b0, "post_rst_d3_a");
    pseg(0, "g", 1'b0, 1'b0, 1'b0, "post_rst_d0_g");
    lz_blank = 1'b1;
    pseg(3, "a", 1'b0, 1'b0, 1'b0, "post_rst_lz_d3_a");
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "post_rst_lz_d0_a");
    lz_blank = 1'b0;

    do_load(16'h1234);
    do_fs(1'b0, 16'h0);
    probe(248, 221, 1'b0, 1'b1, 1'b0, "n1234_d3_u0_a_off");
    probe(268, 230, 1'b1, 1'b0, 1'b0, "n1234_d3_b_on");
    pseg(2, "e", 1'b1, 1'b0, 1'b0, "n1234_d2_e");
    pseg(2, "c", 1'b0, 1'b0, 1'b0, "n1234_d2_c");
    pseg(1, "g", 1'b1, 1'b0, 1'b0, "n1234_d1_g");
    pseg(0, "f", 1'b1, 1'b0, 1'b0, "n1234_d0_f");
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "n1234_d0_a");
    probe(271, 230, 1'b1, 1'b0, 1'b0, "edge_u23");
    probe(272, 230, 1'b0, 1'b0, 1'b0, "edge_u24");
    probe(340, 259, 1'b1, 1'b0, 1'b0, "edge_v39");
    probe(340, 260, 1'b0, 1'b0, 1'b0, "edge_v40");
    probe(340, 219, 1'b0, 1'b0, 1'b0, "edge_vneg");
    center_x = 11'd20;
    probe(2018, 230, 1'b0, 1'b0, 1'b0, "no_wrap_far_x");
    probe(0, 221, 1'b1, 1'b0, 1'b0, "moved_centre_d2_a");
    center_x = 11'd320;

    do_load(16'h00A5);
    pseg(3, "b", 1'b1, 1'b1, 1'b1, "a5_held_before_fs");
    do_fs(1'b0, 16'h0);
    pseg(1, "g", 1'b1, 1'b1, 1'b0, "a5_d1_g");
    pseg(1, "d", 1'b0, 1'b0, 1'b0, "a5_d1_d");
    pseg(0, "b", 1'b0, 1'b0, 1'b0, "a5_d0_b");
    pseg(0, "f", 1'b1, 1'b0, 1'b0, "a5_d0_f");

    do_load(16'h0005);
    do_fs(1'b0, 16'h0);
    lz_blank = 1'b1;
    pseg(3, "a", 1'b0, 1'b0, 1'b0, "lz_d3_a");
    pseg(2, "f", 1'b0, 1'b0, 1'b0, "lz_d2_f");
    pseg(1, "d", 1'b0, 1'b0, 1'b0, "lz_d1_d");
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "lz_d0_a");
    pseg(0, "b", 1'b0, 1'b0, 1'b0, "lz_d0_b");
    pseg(0, "c", 1'b1, 1'b0, 1'b0, "lz_d0_c");
    lz_blank = 1'b0;
    pseg(1, "a", 1'b1, 1'b0, 1'b0, "nolz_d1_a");
    pseg(2, "e", 1'b1, 1'b0, 1'b0, "nolz_d2_e");
    pseg(3, "g", 1'b0, 1'b0, 1'b0, "nolz_d3_g");

    do_load(16'h1005);
    do_fs(1'b0, 16'h0);
    lz_blank = 1'b1;
    pseg(2, "a", 1'b1, 1'b0, 1'b0, "lz_inner_zero_kept");
    pseg(3, "b", 1'b1, 1'b0, 1'b0, "lz_top_one");
    lz_blank = 1'b0;

    do_load(16'h1111);
    do_fs(1'b1, 16'h2222);
    pseg(0, "b", 1'b1, 1'b1, 1'b1, "same_cycle_old_b");
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "same_cycle_old_a");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b1, 1'b0, "same_cycle_new_a");
    pseg(0, "c", 1'b0, 1'b0, 1'b0, "same_cycle_new_c");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "fs_no_pending_keeps");

    do_load(16'h8888);
    pseg(0, "a", 1'b1, 1'b1, 1'b1, "pre_reset_lit");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(show, 1'b0, "async_reset_show");
    chk(pending, 1'b0, "async_reset_pending");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    blink_en = 1'b1;
    pseg(0, "a", 1'b1, 1'b1, 1'b0, "blink_n0");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "blink_n1");
    pseg(0, "g", 1'b0, 1'b1, 1'b0, "pending_discarded");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "blink_n2");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "blink_n3");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "blink_n4");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "blink_n5");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "blink_n6");
    blink_en = 1'b0;
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "blink_off_n6");
    blink_en = 1'b1;
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b0, 1'b0, 1'b0, "blink_n7");
    do_fs(1'b0, 16'h0);
    pseg(0, "a", 1'b1, 1'b0, 1'b0, "blink_n8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
